// File: rtl/escritor_framebuffer.sv
// Framebuffer writer: buffers Sobel pixels in a small skid FIFO and writes one frame to memory.
// Optional macro ESCRITOR_BINARIZAR_EN stores 255/0 against threshold LIMIAR instead of raw pixels.
module escritor_framebuffer #(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  LIMIAR     = 8'd64,
  localparam int unsigned AW        = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    pixel_in,
  input  logic          pixel_valido,
  output logic          enable_kernel,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic          ocupado,
  output logic          frame_pronto,
  output logic          overflow
);

  localparam int unsigned    PW       = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]  LastAddr = AW'(WIDTH * HEIGHT - 1);
  localparam logic [PW:0]    EnLimit  = (PW + 1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [AW-1:0] r_addr;
  logic          r_ovf;

  logic          w_run;
  logic          w_empty;
  logic          w_full;
  logic [PW:0]   w_occ;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_last;
  logic          w_clear;
  logic [7:0]    w_wdata;

  assign w_run   = (r_state == StRun);
  assign w_occ   = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  // Extra pointer bit distinguishes a wrapped (full) FIFO from an empty one.
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_last  = (r_addr == LastAddr);
  assign w_clear = (r_state == StIdle) && start;

  assign mem_we  = w_run && !w_empty;
  assign w_pop   = mem_we && mem_ready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign w_push  = w_run && pixel_valido && (!w_full || w_pop);
  assign w_drop  = w_run && pixel_valido && w_full && !w_pop;

`ifdef ESCRITOR_BINARIZAR_EN
  assign w_wdata = (pixel_in >= LIMIAR) ? 8'hFF : 8'h00;
`else
  assign w_wdata = pixel_in;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (w_pop && w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_addr <= '0;
      r_ovf  <= 1'b0;
    end else if (w_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_addr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        // Counter saturates at the last address; the FSM leaves RUN on that write.
        if (!w_last) r_addr <= r_addr + 1'b1;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else if (w_push) begin
      r_fifo[r_wptr[PW-1:0]] <= w_wdata;
    end
  end

  assign mem_data      = r_fifo[r_rptr[PW-1:0]];
  assign mem_addr      = r_addr;
  assign ocupado       = w_run;
  assign frame_pronto  = (r_state == StDone);
  assign overflow      = r_ovf;
  assign enable_kernel = w_run && (w_occ <= EnLimit);

endmodule

// File: doc/escritor_framebuffer.md
ESCRITOR_FRAMEBUFFER -- requirements
Module: escritor_framebuffer

Interface
REQ-001 Parameter WIDTH, default 160: frame width in pixels.
REQ-002 Parameter HEIGHT, default 120: frame height in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4: skid FIFO entries; power of two, minimum 4.
REQ-004 Parameter LIMIAR, default 64: binarisation threshold, 8 bits.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins frame capture.
REQ-008 pixel_in  in  8  Sobel result pixel.
REQ-009 pixel_valido  in  1  pixel_in is valid this cycle; no backpressure on this side.
REQ-010 enable_kernel  out  1  drives the upstream kernel's enable input.
REQ-011 mem_addr  out  AW  framebuffer word address, where AW = $clog2(WIDTH*HEIGHT).
REQ-012 mem_data  out  8  framebuffer write data.
REQ-013 mem_we  out  1  write request.
REQ-014 mem_ready  in  1  memory accepts the write this cycle.
REQ-015 ocupado  out  1  high in the RUN state.
REQ-016 frame_pronto  out  1  one-cycle pulse after the last write completes.
REQ-017 overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full.

Function
REQ-018 The block SHALL implement a three-state FSM (IDLE, RUN, DONE); the reset state is IDLE.
REQ-019 IDLE→RUN on start=1; the same edge SHALL clear the write counter, FIFO pointers and overflow.
REQ-020 start SHALL be ignored in RUN and in DONE.
REQ-021 RUN→DONE on the edge where the write of address WIDTH*HEIGHT-1 completes (mem_we=1 and mem_ready=1).
REQ-022 DONE→IDLE unconditionally after one cycle; frame_pronto SHALL be 1 only in DONE.
REQ-023 In RUN, a pixel with pixel_valido=1 SHALL be pushed into the FIFO on that edge when the FIFO is not full.
REQ-024 In RUN, a pixel with pixel_valido=1 and a full FIFO, with no pop on the same edge, SHALL be dropped and SHALL set overflow.
REQ-025 When push and pop occur on the same edge with the FIFO full, the push SHALL succeed and overflow SHALL NOT be set.
REQ-026 pixel_valido in IDLE or DONE SHALL be ignored, with no push and no overflow.
REQ-027 mem_we SHALL equal (state==RUN) AND (FIFO non-empty); it is driven from registered state only.
REQ-028 mem_data SHALL be the FIFO head; mem_addr SHALL be the write counter.
REQ-029 A pop and a counter increment SHALL occur only on an edge with mem_we=1 and mem_ready=1; mem_addr and mem_data SHALL be held stable while mem_ready=0.
REQ-030 Minimum latency from pixel_valido to mem_we SHALL be one cycle, because the FIFO is registered with no fall-through.
REQ-031 enable_kernel SHALL equal (state==RUN) AND (FIFO occupancy ≤ FIFO_DEPTH-2); the headroom covers the kernel's one-cycle registered valid lag.
REQ-032 The write counter SHALL NOT wrap; writes end at WIDTH*HEIGHT-1, and FIFO contents remaining at RUN exit SHALL be discarded.
REQ-033 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used to tell full from empty.

Reset
REQ-034 reset_n=0 SHALL force asynchronously: state=IDLE, mem_addr=0, mem_we=0, enable_kernel=0, ocupado=0, frame_pronto=0, overflow=0, FIFO empty.
REQ-035 mem_data after reset SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame without issuing frame_pronto.

Configuration
REQ-037 Macro ESCRITOR_BINARIZAR_EN: when defined, the pushed value SHALL be 255 if pixel_in ≥ LIMIAR, else 0.
REQ-038 When ESCRITOR_BINARIZAR_EN is undefined, pixel_in SHALL be stored unchanged and LIMIAR SHALL be unused.

Verification
REQ-039 WIDTH=4, HEIGHT=3, mem_ready=1, start, then 12 valid pixels 1..12 back-to-back -> addresses 0..11 written with data 1..11,12; one frame_pronto pulse; overflow=0.
REQ-040 Same setup with mem_ready=0 for 3 cycles mid-frame -> enable_kernel drops at occupancy 3; no pixel lost; mem_addr/mem_data held while mem_ready=0.
REQ-041 Force 5 valid pixels while mem_ready=0 with FIFO_DEPTH=4 -> 5th pixel dropped, overflow=1 until the next start.
REQ-042 Full FIFO with push and pop on the same edge -> occupancy stays 4; overflow remains 0.
REQ-043 Pulse reset_n low at address 6 -> all outputs 0 immediately; no frame_pronto; a subsequent start rewrites from address 0.
REQ-044 ESCRITOR_BINARIZAR_EN defined, LIMIAR=64, pixels 63, 64, 200 -> stored values 0, 255, 255.
